// File: rtl/spi_xfer_sched_if.sv
// Bus bundle between the transfer scheduler, its requesters and the SPI slave pins.
// The master modport is the scheduler side; the slave modport is the requester/pin side.
interface spi_xfer_sched_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] tx_data;
    logic [4:0]         len;
    logic               m_tx_negedge;
    logic               m_rx_negedge;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic               done;
    logic [31:0]        rx_data;
    logic               sclk;
    logic               ss;
    logic               mosi;
    logic               miso;

    modport master (
        input  req, tx_data, len, m_tx_negedge, m_rx_negedge, miso,
        output gnt, busy, done, rx_data, sclk, ss, mosi
    );

    modport slave (
        output req, tx_data, len, m_tx_negedge, m_rx_negedge, miso,
        input  gnt, busy, done, rx_data, sclk, ss, mosi
    );
endinterface

// File: rtl/spi_xfer_sched.sv
// Round-robin SPI transfer scheduler: grants one requester at a time and runs a
// 1..32 bit MSB-first transfer with selectable mosi-drive / miso-sample edges.
module spi_xfer_sched #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned DIV  = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_xfer_sched_if.master bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(DIV);
    localparam int unsigned EW = 7;

    typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [31:0]     rx_q, rx_d;
    logic [31:0]     txsh_q, txsh_d;
    logic [31:0]     rxsh_q, rxsh_d;
    logic [5:0]      len_q, len_d;
    logic            txn_q, txn_d;
    logic            rxn_q, rxn_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [EW-1:0]   ecnt_q, ecnt_d;
    logic            sclk_q, sclk_d;
    logic            ss_q, ss_d;
    logic            mosi_q, mosi_d;

    logic [31:0]     words [NREQ];
    logic            found_c;
    logic [PW-1:0]   win_c;
    logic [PW-1:0]   nxt_c;
    logic [PW-1:0]   idx_c;
    int unsigned     j_c;
    logic [5:0]      l_c;
    logic            rising_c;
    logic [EW-1:0]   last_c;

    for (genvar g = 0; g < NREQ; g++) begin : g_word
        assign words[g] = bus.tx_data[g*32 +: 32];
    end

    // Round-robin search starting at the pointer
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        idx_c   = '0;
        j_c     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j_c = 32'(ptr_q) + i;
            if (j_c >= NREQ) j_c = j_c - NREQ;
            idx_c = PW'(j_c);
            if (!found_c && bus.req[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
        nxt_c = (32'(win_c) == NREQ - 1) ? '0 : win_c + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rx_q    <= '0;
            txsh_q  <= '0;
            rxsh_q  <= '0;
            len_q   <= '0;
            txn_q   <= 1'b0;
            rxn_q   <= 1'b0;
            cnt_q   <= '0;
            ecnt_q  <= '0;
            sclk_q  <= 1'b0;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
            txsh_q  <= txsh_d;
            rxsh_q  <= rxsh_d;
            len_q   <= len_d;
            txn_q   <= txn_d;
            rxn_q   <= rxn_d;
            cnt_q   <= cnt_d;
            ecnt_q  <= ecnt_d;
            sclk_q  <= sclk_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        done_d   = 1'b0;
        rx_d     = rx_q;
        txsh_d   = txsh_q;
        rxsh_d   = rxsh_q;
        len_d    = len_q;
        txn_d    = txn_q;
        rxn_d    = rxn_q;
        cnt_d    = cnt_q;
        ecnt_d   = ecnt_q;
        sclk_d   = sclk_q;
        ss_d     = ss_q;
        mosi_d   = mosi_q;
        l_c      = (bus.len == 5'd0) ? 6'd32 : {1'b0, bus.len};
        rising_c = ~sclk_q;
        last_c   = {len_q, 1'b0};

        unique case (state_q)
            IDLE: begin
                if (found_c) begin
                    gnt_d        = '0;
                    gnt_d[win_c] = 1'b1;
                    ptr_d        = nxt_c;
                    len_d        = l_c;
                    txn_d        = bus.m_tx_negedge;
                    rxn_d        = bus.m_rx_negedge;
                    // Left-align the active bits so the next bit out is always bit 31
                    txsh_d       = words[win_c] << (6'd32 - l_c);
                    mosi_d       = bus.m_tx_negedge ? words[win_c][bus.len - 5'd1] : 1'b0;
                    rxsh_d       = '0;
                    cnt_d        = '0;
                    ecnt_d       = '0;
                    ss_d         = 1'b0;
                    state_d      = XFER;
                end
            end
            XFER: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    ecnt_d = ecnt_q + 7'd1;
                    if (rising_c != rxn_q) rxsh_d = {rxsh_q[30:0], bus.miso};
                    if (!txn_q && rising_c) begin
                        mosi_d = txsh_q[31];
                        txsh_d = txsh_q << 1;
                    end
                    // Falling-edge drive skips the final edge: bit 0 is already on the wire
                    if (txn_q && !rising_c && ecnt_d != last_c) begin
                        mosi_d = txsh_q[30];
                        txsh_d = txsh_q << 1;
                    end
                    if (ecnt_d == last_c) state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d   = '0;
                    ss_d    = 1'b1;
                    done_d  = 1'b1;
                    rx_d    = rxsh_q;
                    gnt_d   = '0;
                    mosi_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;
    assign bus.sclk    = sclk_q;
    assign bus.ss      = ss_q;
    assign bus.mosi    = mosi_q;
endmodule

// File: tb/tb_spi_xfer_sched.sv
// Bench for spi_xfer_sched: vector table plus corner sequences, with a small SPI
// slave model and a done-triggered scoreboard.
module tb_spi_xfer_sched;
    localparam int unsigned NREQ = 3;
    localparam int unsigned DIV  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_xfer_sched_if #(.NREQ(NREQ)) bus();

    spi_xfer_sched #(.NREQ(NREQ), .DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  gnt;
        logic [31:0] rx;
        logic [31:0] mosi;
        int unsigned edges;
        int unsigned low;
    } exp_t;

    typedef struct {
        logic [1:0]  id;
        logic [4:0]  len;
        logic        txn;
        logic        rxn;
        logic        one;
        logic [31:0] data;
    } vec_t;

    int unsigned tests  = 0;
    int unsigned failed = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] slv_model = '0;
    logic        force_one = 1'b0;
    logic [31:0] sreg      = '0;
    logic        slv_miso  = 1'b0;
    logic        sprev     = 1'b0;

    logic        prev_sclk  = 1'b0;
    int unsigned edges      = 0;
    logic [31:0] mosi_acc   = '0;
    int unsigned low_cycles = 0;
    logic [2:0]  seen_gnt   = '0;
    logic        gnt_bad    = 1'b0;
    int unsigned done_cnt   = 0;

    assign bus.miso = force_one ? 1'b1 : slv_miso;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mask32(input int unsigned l);
        logic [63:0] t;
        t = (64'd1 << l) - 64'd1;
        return t[31:0];
    endfunction

    function automatic logic [31:0] top_bits(input logic [31:0] m, input int unsigned l);
        logic [63:0] t;
        t = {32'b0, m} >> (32 - l);
        return t[31:0];
    endfunction

    // Expected outcome from the slave model; advance the model by the bits shifted in
    task automatic push_exp(input logic [1:0] id, input logic [4:0] len,
                            input logic [31:0] data, input logic one);
        exp_t        e;
        int unsigned l;
        logic [63:0] t;
        l       = (len == 5'd0) ? 32 : 32'(len);
        e.gnt   = 3'b001 << id;
        e.rx    = one ? mask32(l) : top_bits(slv_model, l);
        e.mosi  = data & mask32(l);
        e.edges = 2 * l;
        e.low   = (2 * l + 1) * DIV;
        t = {32'b0, slv_model} << l;
        slv_model = t[31:0] | (data & mask32(l));
        exp_q.push_back(e);
    endtask

    // SPI slave: shifts in mosi and shifts out its register on rising sclk
    always @(negedge clk) begin
        if (rst) begin
            sreg     = '0;
            slv_miso = 1'b0;
            sprev    = 1'b0;
        end else begin
            if (bus.sclk && !sprev) begin
                slv_miso = sreg[31];
                sreg     = {sreg[30:0], bus.mosi};
            end
            sprev = bus.sclk;
        end
    end

    // Monitor and scoreboard consumer
    always @(negedge clk) begin
        if (rst) begin
            prev_sclk  = 1'b0;
            edges      = 0;
            mosi_acc   = '0;
            low_cycles = 0;
            seen_gnt   = '0;
            gnt_bad    = 1'b0;
        end else begin
            if (bus.sclk !== prev_sclk) begin
                edges++;
                if (bus.sclk) mosi_acc = {mosi_acc[30:0], bus.mosi};
            end
            prev_sclk = bus.sclk;
            if (!bus.ss) low_cycles++;
            if (bus.gnt != '0) begin
                seen_gnt = bus.gnt;
                if (!$onehot(bus.gnt)) gnt_bad = 1'b1;
            end
            if (bus.done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_done", 64'(bus.done), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_gnt",     64'(seen_gnt),    64'(mon_e.gnt));
                    chk("sb_rx_data", 64'(bus.rx_data), 64'(mon_e.rx));
                    chk("sb_mosi",    64'(mosi_acc),    64'(mon_e.mosi));
                    chk("sb_edges",   64'(edges),       64'(mon_e.edges));
                    chk("sb_ss_low",  64'(low_cycles),  64'(mon_e.low));
                    chk("sb_onehot",  64'(gnt_bad),     64'(0));
                    chk("sb_end_pins", 64'({bus.ss, bus.sclk, bus.gnt}), 64'({1'b1, 1'b0, 3'b000}));
                end
                edges      = 0;
                mosi_acc   = '0;
                low_cycles = 0;
                gnt_bad    = 1'b0;
            end
        end
    end

    task automatic wait_gnt(input string name);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.gnt != '0) return;
        end
        chk(name, 64'(bus.gnt != '0), 64'(1));
    endtask

    task automatic wait_done(input string name);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        chk(name, 64'(bus.done), 64'(1));
    endtask

    task automatic load_words(input logic [1:0] id, input logic [31:0] data);
        logic [31:0] w [3];
        for (int k = 0; k < 3; k++) w[k] = $urandom;
        w[id] = data;
        bus.tx_data = {w[2], w[1], w[0]};
    endtask

    task automatic run_vec(input vec_t v);
        force_one        = v.one;
        load_words(v.id, v.data);
        bus.len          = v.len;
        bus.m_tx_negedge = v.txn;
        bus.m_rx_negedge = v.rxn;
        push_exp(v.id, v.len, v.data, v.one);
        bus.req = 3'b001 << v.id;
        wait_gnt("vec_gnt_timeout");
        bus.req = '0;
        wait_done("vec_done_timeout");
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [8];
        int unsigned cnt;
        int unsigned ecount;
        int unsigned done_before;
        logic        ps;

        vecs[0] = '{2'd0, 5'd0,  1'b1, 1'b1, 1'b0, 32'hA5A5_0F0F};
        vecs[1] = '{2'd0, 5'd0,  1'b1, 1'b1, 1'b0, 32'h1234_5678};
        vecs[2] = '{2'd2, 5'd8,  1'b1, 1'b1, 1'b0, 32'h0000_00C3};
        vecs[3] = '{2'd1, 5'd1,  1'b1, 1'b1, 1'b0, 32'h0000_0001};
        vecs[4] = '{2'd2, 5'd31, 1'b0, 1'b1, 1'b0, 32'h7ABC_DEF1};
        vecs[5] = '{2'd1, 5'd5,  1'b0, 1'b0, 1'b1, 32'h0000_0015};
        vecs[6] = '{2'd0, 5'd16, 1'b1, 1'b0, 1'b1, 32'h0000_BEEF};
        vecs[7] = '{2'd2, 5'd3,  1'b0, 1'b1, 1'b0, 32'h0000_0005};

        bus.req          = '0;
        bus.tx_data      = '0;
        bus.len          = '0;
        bus.m_tx_negedge = 1'b1;
        bus.m_rx_negedge = 1'b1;

        // Reset and idle behaviour
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("reset_idle",
                64'({bus.gnt, bus.busy, bus.done, bus.sclk, bus.ss, bus.mosi, bus.rx_data}),
                64'({3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0}));
        end

        // Round-robin with all requests held
        bus.tx_data = {32'h0000_000C, 32'h0000_0006, 32'h0000_0009};
        bus.len     = 5'd4;
        for (int k = 0; k < 6; k++) begin
            logic [1:0] rid;
            rid = 2'(k % 3);
            push_exp(rid, 5'd4, bus.tx_data[rid*32 +: 32], 1'b0);
        end
        bus.req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k > 0) chk("rr_gap_ss", 64'(bus.ss), 64'(0));
            chk("rr_order", 64'(bus.gnt), 64'(3'b001 << (k % 3)));
            if (k == 5) bus.req = '0;
            wait_done("rr_done_timeout");
        end
        @(negedge clk);
        chk("rr_idle_busy", 64'(bus.busy), 64'(0));

        // Table of transfers
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
            if (i == 1) chk("echo_32", 64'(bus.rx_data), 64'(32'hA5A5_0F0F));
        end

        // 8-bit cycle timing from the request edge
        force_one        = 1'b0;
        load_words(2'd0, 32'h0000_00C3);
        bus.len          = 5'd8;
        bus.m_tx_negedge = 1'b1;
        bus.m_rx_negedge = 1'b1;
        push_exp(2'd0, 5'd8, 32'h0000_00C3, 1'b0);
        bus.req = 3'b001;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (bus.gnt != '0) bus.req = '0;
            if (bus.done) break;
        end
        chk("t8_done_latency", 64'(cnt), 64'(69));
        chk("t8_rx_upper", 64'(bus.rx_data[31:8]), 64'(0));
        @(negedge clk);

        // Requester 1 drops its request halfway through a 16-bit transfer
        done_before = done_cnt;
        load_words(2'd1, 32'h0000_5AC3);
        bus.len = 5'd16;
        push_exp(2'd1, 5'd16, 32'h0000_5AC3, 1'b0);
        bus.req = 3'b010;
        wait_gnt("drop_gnt_timeout");
        ps = bus.sclk;
        ecount = 0;
        for (int c = 0; c < 400 && ecount < 16; c++) begin
            @(negedge clk);
            if (bus.sclk !== ps) ecount++;
            ps = bus.sclk;
        end
        bus.req = '0;
        wait_done("drop_done_timeout");
        repeat (30) @(negedge clk);
        chk("drop_done_once", 64'(done_cnt), 64'(done_before + 1));

        // Reset at sclk edge 10 of a 16-bit transfer
        done_before = done_cnt;
        load_words(2'd0, 32'h0000_F00D);
        bus.req = 3'b001;
        wait_gnt("abort_gnt_timeout");
        bus.req = '0;
        ps = bus.sclk;
        ecount = 0;
        for (int c = 0; c < 400 && ecount < 10; c++) begin
            @(negedge clk);
            if (bus.sclk !== ps) ecount++;
            ps = bus.sclk;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_pins",
            64'({bus.ss, bus.sclk, bus.gnt, bus.done, bus.busy}),
            64'({1'b1, 1'b0, 3'b000, 1'b0, 1'b0}));
        repeat (2) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(done_before));
        exp_q.delete();
        slv_model = '0;
        rst = 1'b0;
        @(negedge clk);

        // After reset the pointer restarts at requester 0
        bus.tx_data = {32'h0, 32'h0000_000A, 32'h0000_0003};
        bus.len     = 5'd4;
        push_exp(2'd0, 5'd4, 32'h0000_0003, 1'b0);
        bus.req = 3'b011;
        wait_gnt("post_reset_gnt_timeout");
        chk("post_reset_gnt", 64'(bus.gnt), 64'(3'b001));
        bus.req = '0;
        wait_done("post_reset_done_timeout");
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
